linear_solver: RTL and testbench
================================

// Module: linear_solver
// PURPOSE
//  Sequential trilateration solver: from four reference points (x_i,y_i,z_i)
//  and their ranges r_i, computes the unknown position (c1,c2,c3).
//  Linearises the sphere equations by subtracting equation 1 from 2..4,
//  then solves the resulting 3x3 system by Cramer's rule.
//  Used as the position-fix stage after range/coordinate acquisition.
// PARAMETERS
//  none (all arithmetic is IEEE-754 double precision, port type real)
// PORTS
//  clk    in   1     rising-edge clock (single clock domain)
//  rst_n  in   1     asynchronous reset, active low
//  x1..x4 in   real  X coordinate of reference point 1..4
//  y1..y4 in   real  Y coordinate of reference point 1..4
//  z1..z4 in   real  Z coordinate of reference point 1..4
//  r1..r4 in   real  range from the unknown point to reference point 1..4
//  c1     out  real  solved X position (registered)
//  c2     out  real  solved Y position (registered)
//  c3     out  real  solved Z position (registered)
//  done   out  1     result valid (registered)
//  state  out  4     current FSM state code
//  en     in   1     start / hold request
// BEHAVIOUR
//  Reset (rst_n=0, async): state=0, done=0, c1=c2=c3=0.0, internal regs 0.0.
//  Math, for i=2..4 (row k=i-1):
//   A[k]=(2(xi-x1), 2(yi-y1), 2(zi-z1))
//   b[k]=(r1^2-ri^2)+(xi^2+yi^2+zi^2)-(x1^2+y1^2+z1^2)
//   D=det(A); c1=Dx/D, c2=Dy/D, c3=Dz/D (Dx: column 1 replaced by b, etc.)
//  FSM, one transition per rising edge:
//   0 IDLE  : done=0; en=1 -> 1, else stay
//   1 LOAD  : latch all 16 inputs into internal regs -> 2
//   2 MAT   : compute A from latched values -> 3
//   3 RHS   : compute b -> 4
//   4 DET   : compute D -> 5
//   5 DX    : compute Dx -> 6
//   6 DY    : compute Dy -> 7
//   7 DZ    : compute Dz -> 8
//   8 DIV   : D==0.0 -> 10; else c1..c3 <= Dx/D,Dy/D,Dz/D -> 9
//   9 DONE  : done=1; en=1 stay; en=0 -> 0
//   10 SING : c1=c2=c3=0.0, done=1; en=1 stay; en=0 -> 0
//   11..15  : illegal; -> 0 next edge
//  Latency: en high at IDLE edge -> done=1 nine edges later.
//  Inputs are sampled only in LOAD; changes afterwards do not affect result.
//  en is ignored in states 1..8 (computation always completes).
//  c1..c3 hold last result until next DIV/SING or reset.
//  Reset mid-computation aborts immediately to IDLE with reset values.
//  state output equals the FSM register directly.
// TESTING
//  1 Refs (0,0,0),(10,0,0),(0,10,0),(0,0,10); r=sqrt14,sqrt94,sqrt74,sqrt54;
//    en=1 -> done at edge 9, state=9, c=(1,2,3) within 1e-9.
//  2 Same refs, target (-4,7.5,0): r=sqrt(72.25),sqrt(252.25),sqrt(22.25),
//    sqrt(172.25) -> c=(-4,7.5,0) within 1e-9.
//  3 Coplanar refs, all z=0: (0,0,0),(1,0,0),(0,1,0),(1,1,0), r=1 each
//    -> state=10, done=1, c=(0,0,0).
//  4 GPS-scale set x=(2088202.299,11092568.240,35606984.591,3966929.048),
//    y=(-11757191.370,-14198201.090,94447027.237,7362851.831),
//    z=(25391471.881,21471165.950,9101378.572,26388447.172),
//    r=(23204698.51,21585835.37,31364260.01,24966798.73): done after 9
//    edges; A*c-b residual < 1e-6*|b| per row.
//  5 Drop rst_n at state 5 -> state=0, done=0, c=0 at once; rerun test 1 ok.
//  6 After done, en=0 -> state 0, done=0 next edge; c1..c3 retain result.

Source files
------------

// File: rtl/linear_solver.sv
// Trilateration position solver.
// Latches four reference points and their ranges, linearises the sphere
// equations against point 1 into a 3x3 system A*c = b, and solves it by
// Cramer's rule, one arithmetic step per clock. A zero determinant is
// reported as a singular result with c1..c3 forced to 0.0.
module linear_solver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  real        x1,
    input  real        x2,
    input  real        x3,
    input  real        x4,
    input  real        y1,
    input  real        y2,
    input  real        y3,
    input  real        y4,
    input  real        z1,
    input  real        z2,
    input  real        z3,
    input  real        z4,
    input  real        r1,
    input  real        r2,
    input  real        r3,
    input  real        r4,
    output real        c1,
    output real        c2,
    output real        c3,
    output logic       done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LOAD = 4'd1,
        S_MAT  = 4'd2,
        S_RHS  = 4'd3,
        S_DET  = 4'd4,
        S_DX   = 4'd5,
        S_DY   = 4'd6,
        S_DZ   = 4'd7,
        S_DIV  = 4'd8,
        S_DONE = 4'd9,
        S_SING = 4'd10
    } state_t;

    state_t state_q;
    state_t state_d;

    // Latched reference points (index 0 is point 1) and ranges.
    real px [4];
    real py [4];
    real pz [4];
    real pr [4];

    // Linearised system and its determinants.
    real a  [3][3];
    real b  [3];
    real d;
    real dx;
    real dy;
    real dz;

    function automatic real norm2(input real x, input real y, input real z);
        return x * x + y * y + z * z;
    endfunction

    // Determinant of a 3x3 matrix given row by row.
    function automatic real det3(input real m11, input real m12, input real m13,
                                 input real m21, input real m22, input real m23,
                                 input real m31, input real m32, input real m33);
        return m11 * (m22 * m33 - m23 * m32)
             - m12 * (m21 * m33 - m23 * m31)
             + m13 * (m21 * m32 - m22 * m31);
    endfunction

    assign state = state_q;

    // State register; done is registered from the next state so it rises
    // together with the DONE/SING state code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for every flop so all registers
            // update from the same pre-edge values.
            state_q <= state_d;
            done    <= (state_d == S_DONE) || (state_d == S_SING);
        end
    end

    // Next-state decode; computation states always run to completion.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = en ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_MAT;
            S_MAT:   state_d = S_RHS;
            S_RHS:   state_d = S_DET;
            S_DET:   state_d = S_DX;
            S_DX:    state_d = S_DY;
            S_DY:    state_d = S_DZ;
            S_DZ:    state_d = S_DIV;
            S_DIV:   state_d = (d == 0.0) ? S_SING : S_DONE;
            S_DONE:  state_d = en ? S_DONE : S_IDLE;
            S_SING:  state_d = en ? S_SING : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: one arithmetic step per state; results hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every datapath register is reset so an aborted run never
            // leaves stale partial results behind.
            for (int i = 0; i < 4; i++) begin
                px[i] <= 0.0;
                py[i] <= 0.0;
                pz[i] <= 0.0;
                pr[i] <= 0.0;
            end
            for (int k = 0; k < 3; k++) begin
                b[k] <= 0.0;
                for (int j = 0; j < 3; j++) a[k][j] <= 0.0;
            end
            d  <= 0.0;
            dx <= 0.0;
            dy <= 0.0;
            dz <= 0.0;
            c1 <= 0.0;
            c2 <= 0.0;
            c3 <= 0.0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    px[0] <= x1; px[1] <= x2; px[2] <= x3; px[3] <= x4;
                    py[0] <= y1; py[1] <= y2; py[2] <= y3; py[3] <= y4;
                    pz[0] <= z1; pz[1] <= z2; pz[2] <= z3; pz[3] <= z4;
                    pr[0] <= r1; pr[1] <= r2; pr[2] <= r3; pr[3] <= r4;
                end
                S_MAT: begin
                    for (int k = 0; k < 3; k++) begin
                        a[k][0] <= 2.0 * (px[k+1] - px[0]);
                        a[k][1] <= 2.0 * (py[k+1] - py[0]);
                        a[k][2] <= 2.0 * (pz[k+1] - pz[0]);
                    end
                end
                S_RHS: begin
                    for (int k = 0; k < 3; k++) begin
                        b[k] <= (pr[0] * pr[0] - pr[k+1] * pr[k+1])
                              + norm2(px[k+1], py[k+1], pz[k+1])
                              - norm2(px[0], py[0], pz[0]);
                    end
                end
                S_DET: d  <= det3(a[0][0], a[0][1], a[0][2],
                                  a[1][0], a[1][1], a[1][2],
                                  a[2][0], a[2][1], a[2][2]);
                S_DX:  dx <= det3(b[0], a[0][1], a[0][2],
                                  b[1], a[1][1], a[1][2],
                                  b[2], a[2][1], a[2][2]);
                S_DY:  dy <= det3(a[0][0], b[0], a[0][2],
                                  a[1][0], b[1], a[1][2],
                                  a[2][0], b[2], a[2][2]);
                S_DZ:  dz <= det3(a[0][0], a[0][1], b[0],
                                  a[1][0], a[1][1], b[1],
                                  a[2][0], a[2][1], b[2]);
                S_DIV: begin
                    if (d == 0.0) begin
                        c1 <= 0.0;
                        c2 <= 0.0;
                        c3 <= 0.0;
                    end else begin
                        c1 <= dx / d;
                        c2 <= dy / d;
                        c3 <= dz / d;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_linear_solver.sv
// Self-checking bench for linear_solver: table of directed vectors run
// through the full FSM, plus reset-abort and retention sequences.
module tb_linear_solver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    real        xv [4];
    real        yv [4];
    real        zv [4];
    real        rv [4];
    real        c1;
    real        c2;
    real        c3;
    logic       done;
    logic [3:0] state;

    linear_solver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .x1    (xv[0]), .x2 (xv[1]), .x3 (xv[2]), .x4 (xv[3]),
        .y1    (yv[0]), .y2 (yv[1]), .y3 (yv[2]), .y4 (yv[3]),
        .z1    (zv[0]), .z2 (zv[1]), .z3 (zv[2]), .z4 (zv[3]),
        .r1    (rv[0]), .r2 (rv[1]), .r3 (rv[2]), .r4 (rv[3]),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .done  (done),
        .state (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        real   x [4];
        real   y [4];
        real   z [4];
        real   r [4];
        real   ex;
        real   ey;
        real   ez;
        int    est;
        bit    residual;
    } vec_t;

    vec_t vecs [4];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input real act, input real exp, input real tol);
        real diff;
        n_cmp++;
        diff = act - exp;
        if (diff < 0.0) diff = -diff;
        if (!(diff <= tol)) begin
            n_bad++;
            $display("FAIL %s: got %g, expected %g (tol %g)", name, act, exp, tol);
        end
    endtask

    function automatic real absr(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Residual of each row of A*c = b, built from the vector's own inputs.
    task automatic check_residual(input int idx);
        real ar [3];
        real br;
        real res;
        for (int k = 0; k < 3; k++) begin
            ar[0] = 2.0 * (vecs[idx].x[k+1] - vecs[idx].x[0]);
            ar[1] = 2.0 * (vecs[idx].y[k+1] - vecs[idx].y[0]);
            ar[2] = 2.0 * (vecs[idx].z[k+1] - vecs[idx].z[0]);
            br = (vecs[idx].r[0] ** 2 - vecs[idx].r[k+1] ** 2)
               + (vecs[idx].x[k+1] ** 2 + vecs[idx].y[k+1] ** 2 + vecs[idx].z[k+1] ** 2)
               - (vecs[idx].x[0] ** 2 + vecs[idx].y[0] ** 2 + vecs[idx].z[0] ** 2);
            res = ar[0] * c1 + ar[1] * c2 + ar[2] * c3 - br;
            check($sformatf("%s residual row %0d (relative)", vecs[idx].name, k),
                  absr(res) / absr(br), 0.0, 1e-6);
        end
    endtask

    task automatic check_result(input int idx, input string tag);
        if (vecs[idx].residual) begin
            check_residual(idx);
        end else begin
            check({vecs[idx].name, " ", tag, " c1"}, c1, vecs[idx].ex, 1e-9);
            check({vecs[idx].name, " ", tag, " c2"}, c2, vecs[idx].ey, 1e-9);
            check({vecs[idx].name, " ", tag, " c3"}, c3, vecs[idx].ez, 1e-9);
        end
    endtask

    task automatic drive_inputs(input int idx);
        for (int i = 0; i < 4; i++) begin
            xv[i] = vecs[idx].x[i];
            yv[i] = vecs[idx].y[i];
            zv[i] = vecs[idx].z[i];
            rv[i] = vecs[idx].r[i];
        end
    endtask

    // Full run: inputs are scrambled after LOAD and en is dropped mid-run to
    // confirm both are ignored once computation starts.
    task automatic run_vec(input int idx);
        int edges;
        bit got;
        edges = 0;
        got   = 1'b0;
        drive_inputs(idx);
        @(negedge clk);
        en = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            if (!got) begin
                @(posedge clk);
                #1;
                if (e == 2) begin
                    for (int i = 0; i < 4; i++) begin
                        xv[i] = 123.0 + i;
                        yv[i] = -77.0 * i;
                        zv[i] = 5.5 * i * i;
                        rv[i] = 999.0;
                    end
                end
                if (e == 3) en = 1'b0;
                if (e == 8) en = 1'b1;
                if (done === 1'b1) begin
                    got   = 1'b1;
                    edges = e;
                end
            end
        end
        check({vecs[idx].name, " edges to done"}, real'(edges), 9.0, 0.0);
        check({vecs[idx].name, " state at done"}, real'(state), real'(vecs[idx].est), 0.0);
        check_result(idx, "result");
        @(posedge clk);
        #1;
        check({vecs[idx].name, " hold state en=1"}, real'(state), real'(vecs[idx].est), 0.0);
        check({vecs[idx].name, " hold done en=1"}, real'(done), 1.0, 0.0);
        en = 1'b0;
        @(posedge clk);
        #1;
        check({vecs[idx].name, " state after en=0"}, real'(state), 0.0, 0.0);
        check({vecs[idx].name, " done after en=0"}, real'(done), 0.0, 0.0);
        check_result(idx, "retained");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].name = "axis_123";
        vecs[0].x = '{0.0, 10.0, 0.0, 0.0};
        vecs[0].y = '{0.0, 0.0, 10.0, 0.0};
        vecs[0].z = '{0.0, 0.0, 0.0, 10.0};
        vecs[0].r = '{$sqrt(14.0), $sqrt(94.0), $sqrt(74.0), $sqrt(54.0)};
        vecs[0].ex = 1.0; vecs[0].ey = 2.0; vecs[0].ez = 3.0;
        vecs[0].est = 9; vecs[0].residual = 1'b0;

        vecs[1].name = "axis_neg";
        vecs[1].x = '{0.0, 10.0, 0.0, 0.0};
        vecs[1].y = '{0.0, 0.0, 10.0, 0.0};
        vecs[1].z = '{0.0, 0.0, 0.0, 10.0};
        vecs[1].r = '{$sqrt(72.25), $sqrt(252.25), $sqrt(22.25), $sqrt(172.25)};
        vecs[1].ex = -4.0; vecs[1].ey = 7.5; vecs[1].ez = 0.0;
        vecs[1].est = 9; vecs[1].residual = 1'b0;

        vecs[2].name = "coplanar";
        vecs[2].x = '{0.0, 1.0, 0.0, 1.0};
        vecs[2].y = '{0.0, 0.0, 1.0, 1.0};
        vecs[2].z = '{0.0, 0.0, 0.0, 0.0};
        vecs[2].r = '{1.0, 1.0, 1.0, 1.0};
        vecs[2].ex = 0.0; vecs[2].ey = 0.0; vecs[2].ez = 0.0;
        vecs[2].est = 10; vecs[2].residual = 1'b0;

        vecs[3].name = "gps";
        vecs[3].x = '{2088202.299, 11092568.240, 35606984.591, 3966929.048};
        vecs[3].y = '{-11757191.370, -14198201.090, 94447027.237, 7362851.831};
        vecs[3].z = '{25391471.881, 21471165.950, 9101378.572, 26388447.172};
        vecs[3].r = '{23204698.51, 21585835.37, 31364260.01, 24966798.73};
        vecs[3].ex = 0.0; vecs[3].ey = 0.0; vecs[3].ez = 0.0;
        vecs[3].est = 9; vecs[3].residual = 1'b1;

        drive_inputs(0);

        // Reset state.
        #2 rst_n = 1'b0;
        #10;
        check("reset state", real'(state), 0.0, 0.0);
        check("reset done", real'(done), 0.0, 0.0);
        check("reset c1", c1, 0.0, 0.0);
        check("reset c2", c2, 0.0, 0.0);
        check("reset c3", c3, 0.0, 0.0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE holds while en is low.
        @(posedge clk);
        #1;
        check("idle with en=0", real'(state), 0.0, 0.0);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Reset in the middle of a run aborts at once.
        drive_inputs(0);
        @(negedge clk);
        en = 1'b1;
        for (int e = 0; e < 5; e++) @(posedge clk);
        #1;
        check("midrun state before reset", real'(state), 5.0, 0.0);
        rst_n = 1'b0;
        #1;
        check("abort state", real'(state), 0.0, 0.0);
        check("abort done", real'(done), 0.0, 0.0);
        check("abort c1", c1, 0.0, 0.0);
        check("abort c2", c2, 0.0, 0.0);
        check("abort c3", c3, 0.0, 0.0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
